// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the MM:SS.cc BCD stopwatch.
//   sw_state_t  : IDLE / RUN / PAUSE control states
//   DIGIT_W     : width of one BCD digit
//   NUM_DIGITS  : digits on the display bus
//   DIG_*       : digit positions on the packed digit bus
//   MOD_*       : modulus of each digit position
//   digit_mod() : modulus lookup by digit position (used in generate loops)
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;

    localparam int unsigned DIG_CC_ONES  = 0;
    localparam int unsigned DIG_CC_TENS  = 1;
    localparam int unsigned DIG_SEC_ONES = 2;
    localparam int unsigned DIG_SEC_TENS = 3;
    localparam int unsigned DIG_MIN_ONES = 4;
    localparam int unsigned DIG_MIN_TENS = 5;

    localparam int unsigned MOD_CC_ONES  = 10;
    localparam int unsigned MOD_CC_TENS  = 10;
    localparam int unsigned MOD_SEC_ONES = 10;
    localparam int unsigned MOD_SEC_TENS = 6;
    localparam int unsigned MOD_MIN_ONES = 10;
    localparam int unsigned MOD_MIN_TENS = 6;

    function automatic int unsigned digit_mod(input int unsigned idx);
        int unsigned m;
        case (idx)
            DIG_CC_ONES:  m = MOD_CC_ONES;
            DIG_CC_TENS:  m = MOD_CC_TENS;
            DIG_SEC_ONES: m = MOD_SEC_ONES;
            DIG_SEC_TENS: m = MOD_SEC_TENS;
            DIG_MIN_ONES: m = MOD_MIN_ONES;
            DIG_MIN_TENS: m = MOD_MIN_TENS;
            default:      m = 10;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One mod-N BCD digit of the stopwatch count chain.
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   clr       in   synchronous clear to zero (wins over inc)
//   inc       in   advance by one this cycle
//   value     out  current digit value, always 0..N-1
//   carry_out out  inc & (value == N-1); feeds the next digit's inc
// carry_out is combinational so a whole ripple lands in a single clock edge.
// -----------------------------------------------------------------------------
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int unsigned N = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [DIGIT_W-1:0] value,
    output logic               carry_out
);

    localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(N - 1);

    logic [DIGIT_W-1:0] r_value;
    logic               w_last;

    assign w_last = (r_value == LAST);

    // Digit register: reset/clear to zero, wrap at N-1, otherwise hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= {DIGIT_W{1'b0}};
        end else if (clr) begin
            r_value <= {DIGIT_W{1'b0}};
        end else if (inc) begin
            if (w_last) begin
                r_value <= {DIGIT_W{1'b0}};
            end else begin
                r_value <= r_value + DIGIT_W'(1);
            end
        end else begin
            r_value <= r_value;
        end
    end

    assign value     = r_value;
    assign carry_out = inc & w_last;

endmodule

// File: rtl/stopwatch_core.sv
// -----------------------------------------------------------------------------
// stopwatch_core
// 6-digit BCD stopwatch (MM:SS.cc) with start/pause/resume, clear and lap freeze.
//   clk        in   system clock (CLK_HZ)
//   rst        in   synchronous active-high reset
//   key_ss     in   start/stop key level (rising edge acts)
//   key_clr    in   clear key level (rising edge acts, beats ss/lap)
//   key_lap    in   lap key level (rising edge acts)
//   digits     out  24-bit BCD bus, digit i at [4i+3:4i], 0 = cc ones
//   running    out  high while in RUN
//   lap_active out  high while the display shows the frozen lap value
//   wrap       out  one-cycle pulse when 59:59.99 rolls over to 00:00.00
// Key events are decoded on the same edge the rising level is first seen.
// -----------------------------------------------------------------------------
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50000000,
    parameter int unsigned TICK_HZ = 100
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                key_ss,
    input  logic                                key_clr,
    input  logic                                key_lap,
    output logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  digits,
    output logic                                running,
    output logic                                lap_active,
    output logic                                wrap
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    // Key edge detection
    logic r_ss_prev, r_clr_prev, r_lap_prev;
    logic w_ss_ev, w_clr_ev, w_lap_ev;
    logic w_ss_act, w_lap_act;

    // Control state and timing
    sw_state_t     r_state, w_state_next;
    logic [PW-1:0] r_presc;
    logic          w_tick;

    // Count chain, lap register, outputs
    logic [NUM_DIGITS-1:0]              w_inc, w_carry;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] w_count;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] r_lap;
    logic                               r_lap_active;
    logic                               r_wrap;

    assign w_ss_ev  = key_ss  & ~r_ss_prev;
    assign w_clr_ev = key_clr & ~r_clr_prev;
    assign w_lap_ev = key_lap & ~r_lap_prev;

    // Clear discards any ss/lap event arriving in the same cycle
    assign w_ss_act  = w_ss_ev  & ~w_clr_ev;
    assign w_lap_act = w_lap_ev & ~w_clr_ev;

    // Previous-level registers for the three keys
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_prev  <= 1'b0;
            r_clr_prev <= 1'b0;
            r_lap_prev <= 1'b0;
        end else begin
            r_ss_prev  <= key_ss;
            r_clr_prev <= key_clr;
            r_lap_prev <= key_lap;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: clear wins, otherwise ss toggles RUN/PAUSE
    always_comb begin
        w_state_next = r_state;
        if (w_clr_ev) begin
            w_state_next = ST_IDLE;
        end else if (w_ss_act) begin
            case (r_state)
                ST_IDLE:  w_state_next = ST_RUN;
                ST_RUN:   w_state_next = ST_PAUSE;
                ST_PAUSE: w_state_next = ST_RUN;
                default:  w_state_next = ST_IDLE;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Tick is decided on the pre-transition state so a pausing edge may still tick
    assign w_tick = (r_state == ST_RUN) && (r_presc == PRESC_LAST) && !w_clr_ev;

    // Prescaler: counts in RUN, holds in PAUSE (partial period kept), zero in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= {PW{1'b0}};
        end else if (w_clr_ev) begin
            r_presc <= {PW{1'b0}};
        end else if (r_state == ST_RUN) begin
            if (r_presc == PRESC_LAST) begin
                r_presc <= {PW{1'b0}};
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end else if (r_state == ST_IDLE) begin
            r_presc <= {PW{1'b0}};
        end else begin
            r_presc <= r_presc;
        end
    end

    assign w_inc[0] = w_tick;
    assign w_inc[NUM_DIGITS-1:1] = w_carry[NUM_DIGITS-2:0];

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        bcd_digit #(
            .N(digit_mod(gi))
        ) u_digit (
            .clk       (clk),
            .rst       (rst),
            .clr       (w_clr_ev),
            .inc       (w_inc[gi]),
            .value     (w_count[gi]),
            .carry_out (w_carry[gi])
        );
    end

    // Lap register: latch live count in RUN, or release an active freeze
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lap        <= '0;
            r_lap_active <= 1'b0;
        end else if (w_clr_ev) begin
            r_lap        <= '0;
            r_lap_active <= 1'b0;
        end else if (w_lap_act) begin
            if ((r_state == ST_RUN) && !r_lap_active) begin
                r_lap        <= w_count;
                r_lap_active <= 1'b1;
            end else if (r_lap_active && (r_state != ST_IDLE)) begin
                r_lap        <= r_lap;
                r_lap_active <= 1'b0;
            end else begin
                r_lap        <= r_lap;
                r_lap_active <= r_lap_active;
            end
        end else begin
            r_lap        <= r_lap;
            r_lap_active <= r_lap_active;
        end
    end

    // Rollover pulse: the top digit's carry fires only when every digit is at max
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_carry[DIG_MIN_TENS];
        end
    end

    // Both mux sources are registers, so no output pipeline is needed
    assign digits     = r_lap_active ? r_lap : w_count;
    assign running    = (r_state == ST_RUN);
    assign lap_active = r_lap_active;
    assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_core
// Self-checking bench for stopwatch_core with CLK_HZ=1000, TICK_HZ=100 (DIV=10).
// The reference model keeps time as an integer number of centiseconds and
// converts to BCD with division; it is advanced once per clock edge.
// -----------------------------------------------------------------------------
module tb_stopwatch_core;

    localparam int DIV = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_ss = 1'b0, key_clr = 1'b0, key_lap = 1'b0;
    logic [23:0] digits;
    logic        running, lap_active, wrap;

    stopwatch_core #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_ss     (key_ss),
        .key_clr    (key_clr),
        .key_lap    (key_lap),
        .digits     (digits),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state (0 idle, 1 run, 2 pause)
    int m_state, m_presc, m_count, m_lap;
    bit m_lap_act, m_wrap;
    bit m_pss, m_pclr, m_plap;

    function automatic logic [23:0] to_bcd(input int c);
        int mm, ss, cc;
        mm = c / 6000;
        ss = (c / 100) % 60;
        cc = c % 100;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
    endfunction

    task automatic model_edge();
        bit ev_ss, ev_clr, ev_lap;
        int old_state, old_count;
        if (rst) begin
            m_state = 0; m_presc = 0; m_count = 0; m_lap = 0;
            m_lap_act = 0; m_wrap = 0; m_pss = 0; m_pclr = 0; m_plap = 0;
        end else begin
            ev_ss  = key_ss  && !m_pss;
            ev_clr = key_clr && !m_pclr;
            ev_lap = key_lap && !m_plap;
            m_pss = key_ss; m_pclr = key_clr; m_plap = key_lap;
            m_wrap = 0;
            if (ev_clr) begin
                m_state = 0; m_presc = 0; m_count = 0; m_lap = 0; m_lap_act = 0;
            end else begin
                old_state = m_state;
                old_count = m_count;
                if (old_state == 1) begin
                    m_presc++;
                    if (m_presc == DIV) begin
                        m_presc = 0;
                        m_count++;
                        if (m_count == 360000) begin
                            m_count = 0;
                            m_wrap  = 1;
                        end
                    end
                end
                if (ev_lap) begin
                    if (old_state == 1 && !m_lap_act) begin
                        m_lap = old_count;
                        m_lap_act = 1;
                    end else if (m_lap_act && old_state != 0) begin
                        m_lap_act = 0;
                    end
                end
                if (ev_ss) m_state = (old_state == 1) ? 2 : 1;
            end
        end
    endtask

    task automatic check(input string name, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        check({name, ".digits"}, digits, to_bcd(m_lap_act ? m_lap : m_count));
        check({name, ".running"}, 24'(running), 24'(m_state == 1));
        check({name, ".lap"}, 24'(lap_active), 24'(m_lap_act));
        check({name, ".wrap"}, 24'(wrap), 24'(m_wrap));
    endtask

    // advance n clock edges; inputs change only #1 after an edge
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            model_edge();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        key_ss = 0; key_clr = 0; key_lap = 0;
        rst = 1;
        cyc(1);
        rst = 0;
    endtask

    // pulse keys for one edge then release
    task automatic pulse(input logic ss, input logic clr, input logic lap);
        key_ss = ss; key_clr = clr; key_lap = lap;
        cyc(1);
        key_ss = 0; key_clr = 0; key_lap = 0;
    endtask

    typedef struct {
        logic        ss, clr, lap;
        int          ncyc;
        logic [23:0] exp_d;
        logic        exp_run, exp_lap;
    } vec_t;

    vec_t tbl [9];
    int   wraps, bad;
    logic [23:0] wrap_digits;
    logic        wrap_run;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 1'b0,    5, 24'h000000, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 1001, 24'h000100, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0,    1, 24'h000100, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b0,  500, 24'h000100, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b0,    1, 24'h000100, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b1,    1, 24'h000100, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 1'b0,  300, 24'h000100, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 1'b1,    1, 24'h000130, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 1'b0,    1, 24'h000000, 1'b0, 1'b0};

        #2;
        // ---- reset state and table-driven sequence ----
        do_reset();
        check("reset.digits", digits, 24'h0);
        check("reset.flags", {21'd0, running, lap_active, wrap}, 24'h0);
        for (int i = 0; i < 9; i++) begin
            pulse(tbl[i].ss, tbl[i].clr, tbl[i].lap);
            if (tbl[i].ncyc > 1) cyc(tbl[i].ncyc - 1);
            check($sformatf("tbl%0d.digits", i), digits, tbl[i].exp_d);
            check($sformatf("tbl%0d.running", i), 24'(running), 24'(tbl[i].exp_run));
            check($sformatf("tbl%0d.lap", i), 24'(lap_active), 24'(tbl[i].exp_lap));
            check_model($sformatf("tbl%0d.model", i));
        end

        // ---- pause keeps the partial prescaler period ----
        do_reset();
        pulse(1, 0, 0);
        cyc(250);
        pulse(1, 0, 0);
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            cyc(1);
            if (digits !== 24'h000025) bad++;
        end
        check("pause.frozen_cycles_bad", 24'(bad), 24'h0);
        pulse(1, 0, 0);
        cyc(74);
        check("pause.resume", digits, 24'h000032);
        check_model("pause");

        // ---- lap freeze while counting continues ----
        do_reset();
        pulse(1, 0, 0);
        cyc(100);
        pulse(0, 0, 1);
        cyc(200);
        check("lap.frozen", digits, 24'h000010);
        check("lap.active", 24'(lap_active), 24'h1);
        pulse(0, 0, 1);
        check("lap.release", digits, 24'h000030);
        check_model("lap");

        // ---- same-cycle events ----
        do_reset();
        pulse(1, 0, 0);
        cyc(50);
        pulse(1, 1, 1);
        check("clrall.digits", digits, 24'h0);
        check("clrall.flags", {21'd0, running, lap_active, wrap}, 24'h0);
        cyc(20);
        check("clrall.stays_idle", {digits, running}, 25'h0);
        do_reset();
        pulse(1, 0, 0);
        cyc(37);
        pulse(1, 0, 1);
        check("sslap.digits", digits, 24'h000003);
        check("sslap.state", {22'd0, running, lap_active}, 24'h1);
        check_model("sslap");

        // ---- held ss key gives a single transition ----
        do_reset();
        key_ss = 1;
        cyc(50);
        key_ss = 0;
        check("held.running", 24'(running), 24'h1);
        check("held.digits", digits, 24'h000004);
        check_model("held");

        // ---- rollover 59:59.99 -> 00:00.00 via backdoor preload ----
        do_reset();
        pulse(1, 0, 0);
        cyc(3);
        pulse(1, 0, 0);
        force dut.g_digit[0].u_digit.r_value = 4'd9;
        force dut.g_digit[1].u_digit.r_value = 4'd9;
        force dut.g_digit[2].u_digit.r_value = 4'd9;
        force dut.g_digit[3].u_digit.r_value = 4'd5;
        force dut.g_digit[4].u_digit.r_value = 4'd9;
        force dut.g_digit[5].u_digit.r_value = 4'd5;
        cyc(1);
        release dut.g_digit[0].u_digit.r_value;
        release dut.g_digit[1].u_digit.r_value;
        release dut.g_digit[2].u_digit.r_value;
        release dut.g_digit[3].u_digit.r_value;
        release dut.g_digit[4].u_digit.r_value;
        release dut.g_digit[5].u_digit.r_value;
        m_count = 359999;
        cyc(1);
        check("roll.preload", digits, 24'h595999);
        pulse(1, 0, 0);
        wraps = 0;
        wrap_digits = 24'hFFFFFF;
        wrap_run = 1'b0;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            if (wrap === 1'b1) begin
                wraps++;
                wrap_digits = digits;
                wrap_run = running;
            end
        end
        check("roll.wrap_pulses", 24'(wraps), 24'h1);
        check("roll.digits", wrap_digits, 24'h0);
        check("roll.running", 24'(wrap_run), 24'h1);
        check_model("roll");

        // ---- reset mid-run with lap active ----
        do_reset();
        pulse(1, 0, 0);
        cyc(12340);
        check("midrst.pre", digits, 24'h001234);
        pulse(0, 0, 1);
        check("midrst.lap", 24'(lap_active), 24'h1);
        rst = 1;
        cyc(1);
        rst = 0;
        check("midrst.digits", digits, 24'h0);
        check("midrst.flags", {21'd0, running, lap_active, wrap}, 24'h0);
        cyc(30);
        check("midrst.idle", {digits, running}, 25'h0);

        // ---- randomized keys against the model ----
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            key_ss  = ($urandom_range(0, 19) == 0) ? ~key_ss  : key_ss;
            key_lap = ($urandom_range(0, 29) == 0) ? ~key_lap : key_lap;
            key_clr = ($urandom_range(0, 199) == 0) ? ~key_clr : key_clr;
            rst     = ($urandom_range(0, 1499) == 0);
            cyc(1);
            rst = 0;
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- 6-digit BCD stopwatch, format MM:SS.cc (minutes, seconds, centiseconds).
- Sits directly upstream of the 6-digit seven-segment scan encoder and drives its digit bus.
- Control comes from three key levels (start/stop, clear, lap) supplied by the board debouncer.
- Provides start/pause/resume, clear, and a lap-freeze display mode.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz (centisecond).
- DIV = CLK_HZ/TICK_HZ is derived, not overridable.
  - CLK_HZ must be an integer multiple of TICK_HZ, and DIV >= 2.
  - Prescaler width is $clog2(DIV).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_ss  in  1  start/stop key level, debounced; acts on its rising edge.
- key_clr  in  1  clear key level, debounced; acts on its rising edge.
- key_lap  in  1  lap key level, debounced; acts on its rising edge.
- digits  out  24  BCD digits; digit i occupies bits [4i+3:4i].
  - Packed layout is equivalent to [5:0][3:0].
  - Digit map: 0 = cc ones, 1 = cc tens, 2 = sec ones, 3 = sec tens, 4 = min ones, 5 = min tens.
- running  out  1  high while state is RUN.
- lap_active  out  1  high while the display is frozen.
- wrap  out  1  one-cycle pulse on rollover from 59:59.99 to 00:00.00.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE; count, lap register and prescaler all 0.
  - Edge-detect registers all 0.
  - digits=0, running=0, lap_active=0, wrap=0.
  - Reset mid-run is identical; no partial state survives.
- Edge detection:
  - One previous-value register per key.
  - Event = key & ~prev. A held key produces exactly one event.
  - Events act on the same clk edge the rising level is sampled; no added latency.
- State machine (IDLE, RUN, PAUSE), on ss event:
  - IDLE -> RUN.
  - RUN -> PAUSE.
  - PAUSE -> RUN.
- Clear event, from any state:
  - Goes to IDLE and zeroes count, lap register, prescaler and lap_active.
  - Clear has priority over ss and lap events in the same cycle; those events are discarded.
- Lap event is evaluated against the pre-transition state:
  - RUN, lap_active=0: copy the live count into the lap register; lap_active=1.
  - RUN or PAUSE, lap_active=1: lap_active=0; the display returns to the live count.
  - IDLE, or PAUSE with lap_active=0: ignored.
  - ss and lap in the same cycle: both are applied. Example: RUN + ss + lap latches the lap, then enters PAUSE.
- Prescaler:
  - Increments only in RUN.
  - At DIV-1 it returns to 0 and asserts an internal tick that cycle.
  - In PAUSE it holds its value, so resume continues a partial period.
  - In IDLE it is 0.
- Count chain on tick:
  - Ripple-carry BCD increment through moduli 10, 10, 10, 6, 10, 6 (digit 0 to 5).
  - Digit 3 and digit 5 wrap 5 -> 0.
  - All updates land in one clk edge; no multi-cycle ripple.
- Rollover:
  - 59:59.99 + tick -> 00:00.00 with wrap=1 for exactly that cycle.
  - State stays RUN.
- Outputs:
  - digits = lap_active ? lap register : count. Both sources are registers, so the output is glitch-free and needs no extra pipeline stage.
  - running = (state==RUN).
- Invariant: no digit ever holds a value above its modulus minus 1.
- Lap freeze does not stop counting; the live count keeps advancing underneath.

Decomposition:
- Package stopwatch_pkg contains:
  - state enum {IDLE, RUN, PAUSE}.
  - Digit moduli constants (10, 10, 10, 6, 10, 6).
  - Digit index names.
  - Digit width constant 4.
- Sub-module bcd_digit, instantiated 6 times:
  - Mod-N BCD counter (N parameter).
  - Inputs: clr, inc; outputs: value[3:0], carry_out (= inc & value==N-1).
- Top level holds: edge detectors, FSM, prescaler, lap register, output mux.

Test Plan (CLK_HZ=1000, TICK_HZ=100, so DIV=10):
- Reset then ss edge, run 1000 clks:
  - digits reads 00:01.00 (hex 0x000100).
  - running=1.
  - Exactly 100 ticks counted.
- Run 250 clks, ss edge, wait 500 clks, ss edge, run 75 clks:
  - Reaches 00:00.32 — 25 ticks plus 7 ticks, proving the partial period is kept.
  - digits is unchanged throughout the pause.
- Lap freeze in RUN at 00:00.10, run 200 clks:
  - digits holds 0x000010 and lap_active=1.
  - Second lap edge shows 0x000030.
- Force count to 59:59.99 (run 359999 ticks or via backdoor), one more tick:
  - digits=0x000000.
  - wrap high for exactly 1 clk.
  - running stays 1.
- Same-cycle events:
  - clr+ss+lap edges in RUN -> IDLE, all zero; ss and lap have no effect.
  - ss+lap in RUN -> lap latched and state PAUSE.
- Hold key_ss high 50 clks from IDLE -> one transition only (RUN).
- Assert rst mid-run at 00:12.34 with lap_active=1 -> next cycle all outputs are 0 and state is IDLE.
